// File: rtl/sysid_check_master_if.sv
// rtl/sysid_check_master_if.sv - Avalon-MM read port between the sysid check master and the sysid slave

interface sysid_check_master_if;
    logic        m_address;
    logic        m_read;
    logic        m_waitrequest;
    logic [31:0] m_readdata;

    modport master (
        output m_address,
        output m_read,
        input  m_waitrequest,
        input  m_readdata
    );

    modport slave (
        input  m_address,
        input  m_read,
        output m_waitrequest,
        output m_readdata
    );
endinterface

// File: rtl/sysid_check_master.sv
// rtl/sysid_check_master.sv - reads sysid ID/timestamp words and flags mismatches or stalls

module sysid_check_master #(
    parameter logic [31:0] EXPECTED_ID  = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS  = 32'h0000_0000,
    parameter int          READ_LATENCY = 0,
    parameter int          TIMEOUT      = 255,
    parameter bit          AUTO_START   = 1'b1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    sysid_check_master_if.master        bus,
    output logic                        busy,
    output logic                        done,
    output logic                        id_ok,
    output logic                        ts_ok,
    output logic                        timeout_err,
    output logic [31:0]                 id_value,
    output logic [31:0]                 ts_value
);

    localparam logic [1:0]  LAT = 2'(READ_LATENCY);
    localparam logic [15:0] TMO = 16'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ID,
        S_LAT_ID,
        S_RD_TS,
        S_LAT_TS,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] stall_cnt;
    logic [15:0] stall_next;
    logic [1:0]  lat_cnt;
    logic [1:0]  lat_next;
    logic        auto_pending;
    logic        kick;
    logic        cap_id;
    logic        cap_ts;
    logic        timed_out;
    logic        rd_next;
    logic        addr_next;
    logic        busy_next;

    // Next-state decode: read issue, latency wait, capture strobes and stall timeout.
    always_comb begin
        state_next = state;
        stall_next = stall_cnt;
        lat_next   = lat_cnt;
        kick       = 1'b0;
        cap_id     = 1'b0;
        cap_ts     = 1'b0;
        timed_out  = 1'b0;

        case (state)
            S_IDLE: begin
                if (start || auto_pending) begin
                    state_next = S_RD_ID;
                    kick       = 1'b1;
                end
            end
            S_RD_ID, S_RD_TS: begin
                if (!bus.m_waitrequest) begin
                    if (LAT == 2'd0) begin
                        if (state == S_RD_ID) begin
                            cap_id     = 1'b1;
                            state_next = S_RD_TS;
                        end else begin
                            cap_ts     = 1'b1;
                            state_next = S_DONE;
                        end
                    end else begin
                        lat_next   = 2'd1;
                        state_next = (state == S_RD_ID) ? S_LAT_ID : S_LAT_TS;
                    end
                end else if (stall_cnt + 16'd1 == TMO) begin
                    timed_out  = 1'b1;
                    state_next = S_DONE;
                end else begin
                    stall_next = stall_cnt + 16'd1;
                end
            end
            S_LAT_ID: begin
                if (lat_cnt == LAT) begin
                    cap_id     = 1'b1;
                    state_next = S_RD_TS;
                end else begin
                    lat_next = lat_cnt + 2'd1;
                end
            end
            S_LAT_TS: begin
                if (lat_cnt == LAT) begin
                    cap_ts     = 1'b1;
                    state_next = S_DONE;
                end else begin
                    lat_next = lat_cnt + 2'd1;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_next = S_RD_ID;
                    kick       = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase

        // Each read phase gets a fresh stall budget.
        if ((state_next == S_RD_ID || state_next == S_RD_TS) && state_next != state) begin
            stall_next = 16'd0;
        end

        rd_next   = (state_next == S_RD_ID) || (state_next == S_RD_TS);
        addr_next = (state_next == S_RD_TS) || (state_next == S_LAT_TS);
        busy_next = rd_next || (state_next == S_LAT_ID) || (state_next == S_LAT_TS);
    end

    // State, counters and registered outputs; bus strobes are registered from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= S_IDLE;
            stall_cnt     <= 16'd0;
            lat_cnt       <= 2'd0;
            auto_pending  <= AUTO_START;
            bus.m_read    <= 1'b0;
            bus.m_address <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            id_ok         <= 1'b0;
            ts_ok         <= 1'b0;
            timeout_err   <= 1'b0;
            id_value      <= 32'd0;
            ts_value      <= 32'd0;
        end else begin
            state         <= state_next;
            stall_cnt     <= stall_next;
            lat_cnt       <= lat_next;
            auto_pending  <= 1'b0;
            bus.m_read    <= rd_next;
            bus.m_address <= addr_next;
            busy          <= busy_next;
            done          <= (state_next == S_DONE);
            if (cap_id) begin
                id_value <= bus.m_readdata;
            end
            if (cap_ts) begin
                ts_value <= bus.m_readdata;
                id_ok    <= (id_value == EXPECTED_ID);
                ts_ok    <= (bus.m_readdata == EXPECTED_TS);
            end
            if (kick) begin
                id_ok       <= 1'b0;
                ts_ok       <= 1'b0;
                timeout_err <= 1'b0;
            end
            if (timed_out) begin
                timeout_err <= 1'b1;
                id_ok       <= 1'b0;
                ts_ok       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sysid_check_master.sv
// tb/tb_sysid_check_master.sv - self-checking bench for sysid_check_master

module tb_sysid_check_master;

    localparam logic [31:0] EID = 32'h5CA3_26A9;
    localparam logic [31:0] ETS = 32'h1234_5678;
    localparam int T0 = 255;
    localparam int T1 = 5;
    localparam int L1 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [1:0]  start;
    logic [1:0]  busy, done, id_ok, ts_ok, tmo;
    logic [31:0] id_val [2];
    logic [31:0] ts_val [2];
    logic [1:0]  m_read, m_addr, wr;
    logic [31:0] rdata [2];

    sysid_check_master_if bus0 ();
    sysid_check_master_if bus1 ();

    assign m_read[0] = bus0.m_read;
    assign m_read[1] = bus1.m_read;
    assign m_addr[0] = bus0.m_address;
    assign m_addr[1] = bus1.m_address;
    assign bus0.m_waitrequest = wr[0];
    assign bus1.m_waitrequest = wr[1];
    assign bus0.m_readdata = rdata[0];
    assign bus1.m_readdata = rdata[1];

    sysid_check_master #(.EXPECTED_ID(EID), .EXPECTED_TS(ETS), .READ_LATENCY(0),
                         .TIMEOUT(T0), .AUTO_START(1'b1)) u_dut0 (
        .clock(clk), .reset(reset), .start(start[0]), .bus(bus0),
        .busy(busy[0]), .done(done[0]), .id_ok(id_ok[0]), .ts_ok(ts_ok[0]),
        .timeout_err(tmo[0]), .id_value(id_val[0]), .ts_value(ts_val[0]));

    sysid_check_master #(.EXPECTED_ID(EID), .EXPECTED_TS(ETS), .READ_LATENCY(L1),
                         .TIMEOUT(T1), .AUTO_START(1'b1)) u_dut1 (
        .clock(clk), .reset(reset), .start(start[1]), .bus(bus1),
        .busy(busy[1]), .done(done[1]), .id_ok(id_ok[1]), .ts_ok(ts_ok[1]),
        .timeout_err(tmo[1]), .id_value(id_val[1]), .ts_value(ts_val[1]));

    function automatic int lat_of(input int i);
        return (i == 0) ? 0 : L1;
    endfunction

    function automatic int tmo_of(input int i);
        return (i == 0) ? T0 : T1;
    endfunction

    // Behavioural sysid slave: wcfg stall cycles per address, fixed latency, random filler on readdata.
    int          wcfg [2][2];
    logic [31:0] dcfg [2][2];
    int          stall [2] = '{0, 0};
    int          pcnt  [2] = '{0, 0};
    logic [31:0] pval  [2];
    logic [31:0] garb  [2];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            wr[i]    = (m_read[i] === 1'b1) && (stall[i] < wcfg[i][m_addr[i]]);
            rdata[i] = garb[i];
            if (lat_of(i) == 0) begin
                if ((m_read[i] === 1'b1) && !wr[i]) rdata[i] = dcfg[i][m_addr[i]];
            end else if (pcnt[i] == 1) begin
                rdata[i] = pval[i];
            end
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            garb[i] <= $urandom;
            if ((m_read[i] === 1'b1) && wr[i]) stall[i] <= stall[i] + 1;
            else stall[i] <= 0;
            if ((m_read[i] === 1'b1) && !wr[i]) begin
                pcnt[i] <= lat_of(i);
                pval[i] <= dcfg[i][m_addr[i]];
            end else if (pcnt[i] != 0) begin
                pcnt[i] <= pcnt[i] - 1;
            end
        end
    end

    // Bus monitor: read cycles per address, strobes outside busy, address going backwards mid-check.
    int   nrd [2][2] = '{'{0, 0}, '{0, 0}};
    int   bad = 0;
    logic [1:0] pbusy = 2'b00;
    logic [1:0] paddr = 2'b00;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (m_read[i] === 1'b1) begin
                nrd[i][m_addr[i]] = nrd[i][m_addr[i]] + 1;
                if (busy[i] !== 1'b1) bad = bad + 1;
            end
            if (busy[i] === 1'b1 && pbusy[i] === 1'b1 && paddr[i] === 1'b1 && m_addr[i] === 1'b0)
                bad = bad + 1;
            pbusy[i] = busy[i];
            paddr[i] = m_addr[i];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    // Reference model: captured words persist across checks until a read of that word completes.
    logic [31:0] mdl_id [2] = '{32'd0, 32'd0};
    logic [31:0] mdl_ts [2] = '{32'd0, 32'd0};

    function automatic void mdl_timing(input int i, input int w0, input int w1,
                                       input logic [31:0] d0, input logic [31:0] d1,
                                       output int lat, output logic [2:0] fl);
        int l = lat_of(i);
        int t = tmo_of(i);
        if (w0 >= t) begin
            lat = t;
            fl  = 3'b100;
        end else if (w1 >= t) begin
            lat = 1 + l + w0 + t;
            fl  = 3'b100;
        end else begin
            lat = 2 + 2 * l + w0 + w1;
            fl  = {1'b0, d0 == EID, d1 == ETS};
        end
    endfunction

    function automatic void mdl_words(input int i, input int w0, input int w1,
                                      input logic [31:0] d0, input logic [31:0] d1,
                                      output int n0, output int n1);
        int t = tmo_of(i);
        if (w0 >= t) begin
            n0 = t;
            n1 = 0;
        end else begin
            mdl_id[i] = d0;
            n0 = w0 + 1;
            if (w1 >= t) begin
                n1 = t;
            end else begin
                mdl_ts[i] = d1;
                n1 = w1 + 1;
            end
        end
    endfunction

    task automatic judge(input int i, input string tag, input int lat, input int e_lat,
                         input logic [2:0] e_fl, input int dn0, input int dn1,
                         input int w0, input int w1, input logic [31:0] d0, input logic [31:0] d1);
        int n0, n1;
        mdl_words(i, w0, w1, d0, d1, n0, n1);
        chk({tag, "_latency"}, lat, e_lat);
        chk({tag, "_flags"}, {29'd0, tmo[i], id_ok[i], ts_ok[i]}, {29'd0, e_fl});
        chk({tag, "_id_value"}, id_val[i], mdl_id[i]);
        chk({tag, "_ts_value"}, ts_val[i], mdl_ts[i]);
        chk({tag, "_done_busy"}, {30'd0, done[i], busy[i]}, 32'h2);
        chk({tag, "_reads_a0"}, dn0, n0);
        chk({tag, "_reads_a1"}, dn1, n1);
    endtask

    task automatic chk_zero(input int i, input string tag);
        chk({tag, "_ctl"}, {25'd0, busy[i], done[i], id_ok[i], ts_ok[i], tmo[i], m_read[i], m_addr[i]}, 32'd0);
        chk({tag, "_id"}, id_val[i], 32'd0);
        chk({tag, "_ts"}, ts_val[i], 32'd0);
    endtask

    task automatic run(input int i, input int w0, input int w1, input logic [31:0] d0,
                       input logic [31:0] d1, input int poke,
                       output int lat, output int dn0, output int dn1);
        int s0, s1;
        wcfg[i][0] = w0;
        wcfg[i][1] = w1;
        dcfg[i][0] = d0;
        dcfg[i][1] = d1;
        @(negedge clk);
        s0 = nrd[i][0];
        s1 = nrd[i][1];
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
        chk("start_clears_done", {30'd0, busy[i], done[i]}, 32'h2);
        lat = 0;
        while (lat < 400 && done[i] !== 1'b1) begin
            if (lat == poke) start[i] = 1'b1;
            @(negedge clk);
            start[i] = 1'b0;
            lat++;
        end
        dn0 = nrd[i][0] - s0;
        dn1 = nrd[i][1] - s1;
    endtask

    // Waits for both instances' auto-started checks after reset release and scores them.
    task automatic auto_run(input string tag, input int s00, input int s01, input int s10, input int s11);
        int got [2] = '{-1, -1};
        int e_lat;
        logic [2:0] e_fl;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (c == 0) chk({tag, "_late_data_ignored"}, id_val[1], 32'd0);
            for (int i = 0; i < 2; i++)
                if (got[i] < 0 && done[i] === 1'b1) got[i] = c;
            if (got[0] >= 0 && got[1] >= 0) break;
        end
        for (int i = 0; i < 2; i++) begin
            mdl_timing(i, wcfg[i][0], wcfg[i][1], dcfg[i][0], dcfg[i][1], e_lat, e_fl);
            judge(i, $sformatf("%s%0d", tag, i), got[i], e_lat, e_fl,
                  nrd[i][0] - ((i == 0) ? s00 : s10), nrd[i][1] - ((i == 0) ? s01 : s11),
                  wcfg[i][0], wcfg[i][1], dcfg[i][0], dcfg[i][1]);
        end
    endtask

    typedef struct {
        int          inst;
        int          w0;
        int          w1;
        logic [31:0] d0;
        logic [31:0] d1;
        int          poke;
        int          lat;
        logic [2:0]  fl;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, dn0, dn1, e_lat, w0, w1, poke, inst;
        logic [2:0] e_fl;
        logic [31:0] d0, d1;
        logic found;

        tbl[0] = '{0, 0,    0, EID,          ETS,          -1, 2,  3'b011};
        tbl[1] = '{0, 0,    0, EID,          32'h12345679, -1, 2,  3'b010};
        tbl[2] = '{1, 3,    3, EID,          ETS,          -1, 12, 3'b011};
        tbl[3] = '{1, 1000, 0, 32'hAAAA0000, ETS,          -1, 5,  3'b100};
        tbl[4] = '{0, 2,    1, 32'hFFFFFFFF, ETS,          -1, 5,  3'b001};
        tbl[5] = '{1, 4,    4, EID,          ETS,          -1, 14, 3'b011};
        tbl[6] = '{1, 0,    5, 32'h0BAD0001, 32'h0BAD0002, -1, 8,  3'b100};
        tbl[7] = '{1, 2,    2, EID,          32'h00000001, 3,  10, 3'b010};

        reset = 1'b1;
        start = 2'b00;
        for (int i = 0; i < 2; i++) begin
            wcfg[i][0] = 0;
            wcfg[i][1] = 0;
            dcfg[i][0] = EID;
            dcfg[i][1] = ETS;
        end

        // Reset values, then the automatic check after release.
        repeat (3) @(negedge clk);
        chk_zero(0, "reset0");
        chk_zero(1, "reset1");
        reset = 1'b0;
        auto_run("auto", nrd[0][0], nrd[0][1], nrd[1][0], nrd[1][1]);

        // Directed vectors.
        for (int r = 0; r < 8; r++) begin
            run(tbl[r].inst, tbl[r].w0, tbl[r].w1, tbl[r].d0, tbl[r].d1, tbl[r].poke, lat, dn0, dn1);
            judge(tbl[r].inst, $sformatf("row%0d", r), lat, tbl[r].lat, tbl[r].fl, dn0, dn1,
                  tbl[r].w0, tbl[r].w1, tbl[r].d0, tbl[r].d1);
        end

        // Reset while instance 1 waits out its read latency on the ID word.
        wcfg[0][0] = 0; wcfg[0][1] = 0; dcfg[0][0] = EID; dcfg[0][1] = ETS;
        wcfg[1][0] = 0; wcfg[1][1] = 0; dcfg[1][0] = 32'h11110000; dcfg[1][1] = ETS;
        @(negedge clk);
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (busy[1] === 1'b1 && m_read[1] === 1'b0 && m_addr[1] === 1'b0) found = 1'b1;
        end
        chk("reach_lat_id", {31'd0, found}, 32'd1);
        reset = 1'b1;
        dcfg[1][0] = EID;
        @(negedge clk);
        chk_zero(0, "midreset0");
        chk_zero(1, "midreset1");
        mdl_id = '{32'd0, 32'd0};
        mdl_ts = '{32'd0, 32'd0};
        reset = 1'b0;
        auto_run("rerun", nrd[0][0], nrd[0][1], nrd[1][0], nrd[1][1]);

        // Randomized checks against the reference model.
        for (int r = 0; r < 24; r++) begin
            inst = $urandom_range(0, 1);
            w0   = ($urandom_range(0, 9) == 0) ? 1000 : $urandom_range(0, 6);
            w1   = ($urandom_range(0, 9) == 0) ? 1000 : $urandom_range(0, 6);
            d0   = $urandom_range(0, 1) ? EID : $urandom;
            d1   = $urandom_range(0, 1) ? ETS : $urandom;
            poke = $urandom_range(0, 1) ? -1 : $urandom_range(0, 5);
            mdl_timing(inst, w0, w1, d0, d1, e_lat, e_fl);
            run(inst, w0, w1, d0, d1, poke, lat, dn0, dn1);
            judge(inst, $sformatf("rand%0d", r), lat, e_lat, e_fl, dn0, dn1, w0, w1, d0, d1);
        end

        chk("bus_protocol", bad, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
